// File: rtl/ad9511_spi_config_pkg.sv
// AD9511 SPI frame constants and sequencer state encoding.
// Shared by the table sequencer and the serial shifter.
package ad9511_spi_config_pkg;

  localparam int          FRAME_BITS  = 24;
  localparam logic [12:0] UPDATE_ADDR = 13'h05A;
  localparam logic [7:0]  UPDATE_DATA = 8'h01;
  localparam logic [2:0]  WRITE_1BYTE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_UPD
  } state_t;

endpackage

// File: rtl/ad9511_spi_shifter.sv
// 24-bit MSB-first SPI write shifter with SCLK divider.
// CS rises half an SCLK period after the last falling edge.
module ad9511_spi_shifter
  import ad9511_spi_config_pkg::*;
#(
  parameter int SCLK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  shift_end,
  output logic                  fin,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  sdio
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(SCLK_DIV / 2 - 1);

  logic [DIV_W-1:0]      div;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic                  shifting;
  logic                  holding;

  always_ff @(posedge clk) begin
    shift_end <= 1'b0;
    fin       <= 1'b0;
    if (!reset_n) begin
      div      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      shifting <= 1'b0;
      holding  <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      sdio     <= 1'b0;
    end else if (load && !shifting && !holding) begin
      sr       <= frame;
      sdio     <= frame[FRAME_BITS-1];
      cs_n     <= 1'b0;
      sclk     <= 1'b0;
      div      <= '0;
      bit_cnt  <= '0;
      shifting <= 1'b1;
    end else if (shifting) begin
      if (div == DIV_LAST) begin
        div  <= '0;
        sclk <= 1'b0;
        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
          shifting  <= 1'b0;
          holding   <= 1'b1;
          shift_end <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
          sr      <= {sr[FRAME_BITS-2:0], 1'b0};
          sdio    <= sr[FRAME_BITS-2];
        end
      end else begin
        div <= div + DIV_W'(1);
        if (div == HALF_LAST) sclk <= 1'b1;
      end
    end else if (holding) begin
      if (div == HALF_LAST) begin
        holding <= 1'b0;
        cs_n    <= 1'b1;
        sdio    <= 1'b0;
        fin     <= 1'b1;
        div     <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/ad9511_spi_config.sv
// AD9511 configuration sequencer: table run plus update commit,
// and single host writes arbitrated in idle.
module ad9511_spi_config
  import ad9511_spi_config_pkg::*;
#(
  parameter int N_ENTRIES   = 32,
  parameter int IDX_W       = 5,
  parameter int SCLK_DIV    = 8,
  parameter int CS_GAP      = 8,
  parameter int AUTO_UPDATE = 1
) (
  input  logic             clock_33MHz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             wr_req,
  input  logic [12:0]      wr_addr,
  input  logic [7:0]       wr_data,
  output logic             wr_ack,
  output logic [IDX_W-1:0] tbl_index,
  input  logic [20:0]      tbl_entry,
  output logic             busy,
  output logic             done,
  output logic             cfg_ok,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_sdio
);

  localparam int GAP_W = $clog2(CS_GAP + 2);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_ENTRIES > 0 ? N_ENTRIES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(CS_GAP > 0 ? CS_GAP - 1 : 0);

  state_t                state, state_n;
  logic                  tbl_run, tbl_run_n;
  logic                  upd_sent, upd_sent_n;
  logic [IDX_W-1:0]      idx_n;
  logic [GAP_W-1:0]      gap_cnt, gap_n;
  logic                  ack_n, done_n, cfg_ok_n;
  logic                  load;
  logic [FRAME_BITS-1:0] frame;
  logic                  sh_end, sh_fin;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    tbl_run_n  = tbl_run;
    upd_sent_n = upd_sent;
    idx_n      = tbl_index;
    gap_n      = gap_cnt;
    ack_n      = 1'b0;
    done_n     = 1'b0;
    cfg_ok_n   = cfg_ok;
    load       = 1'b0;
    frame      = {WRITE_1BYTE, UPDATE_ADDR, UPDATE_DATA};
    unique case (state)
      S_IDLE: begin
        // start wins; a pending wr_req waits here unacknowledged
        if (start) begin
          tbl_run_n  = 1'b1;
          upd_sent_n = 1'b0;
          idx_n      = '0;
          if (N_ENTRIES > 0) begin
            state_n = S_FETCH;
          end else if (AUTO_UPDATE != 0) begin
            state_n = S_UPD;
          end else begin
            done_n   = 1'b1;
            cfg_ok_n = 1'b1;
          end
        end else if (wr_req) begin
          tbl_run_n = 1'b0;
          ack_n     = 1'b1;
          state_n   = S_LOAD;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        load    = 1'b1;
        frame   = tbl_run ? {WRITE_1BYTE, tbl_entry}
                          : {WRITE_1BYTE, wr_addr, wr_data};
        state_n = S_SHIFT;
      end
      S_UPD: begin
        load       = 1'b1;
        upd_sent_n = 1'b1;
        state_n    = S_SHIFT;
      end
      S_SHIFT: if (sh_end) state_n = S_HOLD;
      S_HOLD: begin
        if (sh_fin) begin
          state_n = S_GAP;
          gap_n   = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_n = gap_cnt + GAP_W'(1);
        end else if (!tbl_run) begin
          state_n = S_IDLE;
        end else if (!upd_sent && tbl_index != LAST_IDX) begin
          idx_n   = tbl_index + IDX_W'(1);
          state_n = S_FETCH;
        end else if (!upd_sent && AUTO_UPDATE != 0) begin
          state_n = S_UPD;
        end else begin
          done_n   = 1'b1;
          cfg_ok_n = 1'b1;
          idx_n    = '0;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_33MHz) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tbl_run   <= 1'b0;
      upd_sent  <= 1'b0;
      tbl_index <= '0;
      gap_cnt   <= '0;
      wr_ack    <= 1'b0;
      done      <= 1'b0;
      cfg_ok    <= 1'b0;
    end else begin
      state     <= state_n;
      tbl_run   <= tbl_run_n;
      upd_sent  <= upd_sent_n;
      tbl_index <= idx_n;
      gap_cnt   <= gap_n;
      wr_ack    <= ack_n;
      done      <= done_n;
      cfg_ok    <= cfg_ok_n;
    end
  end

  ad9511_spi_shifter #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk       (clock_33MHz),
    .reset_n   (reset_n),
    .load      (load),
    .frame     (frame),
    .shift_end (sh_end),
    .fin       (sh_fin),
    .cs_n      (spi_cs_n),
    .sclk      (spi_sclk),
    .sdio      (spi_sdio)
  );

endmodule

// File: tb/tb_ad9511_spi_config.sv
// Bench for ad9511_spi_config: SPI slave model decodes frames
// and compares them against a queue of expected writes.
module tb_ad9511_spi_config;

  localparam int N      = 3;
  localparam int IW     = 2;
  localparam int CS_GAP = 8;
  localparam int CS_LOW = 196;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          wr_req = 1'b0;
  logic [12:0]   wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_ack, busy, done, cfg_ok;
  logic          spi_cs_n, spi_sclk, spi_sdio;
  logic [IW-1:0] tbl_index;
  logic [20:0]   tbl_entry = '0;
  logic [20:0]   tbl [N];
  logic [20:0]   q [$];

  int n_chk = 0, n_err = 0;
  int frames = 0, done_cnt = 0, ack_cnt = 0;
  int m_cnt = 0, m_bits = 0, m_gap = 1000;
  logic [23:0] m_sh = '0;
  logic [20:0] exp_w;
  logic m_bad = 1'b0, idle_bad = 1'b0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_sdio = 1'b0;

  always #15 clk = ~clk;

  ad9511_spi_config #(
    .N_ENTRIES   (N),
    .IDX_W       (IW),
    .SCLK_DIV    (8),
    .CS_GAP      (CS_GAP),
    .AUTO_UPDATE (1)
  ) dut (
    .clock_33MHz (clk),
    .reset_n     (reset_n),
    .start       (start),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .tbl_index   (tbl_index),
    .tbl_entry   (tbl_entry),
    .busy        (busy),
    .done        (done),
    .cfg_ok      (cfg_ok),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_sdio    (spi_sdio)
  );

  always @(posedge clk) tbl_entry <= tbl[tbl_index];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      m_bits = 0;
      m_cnt  = 0;
      m_gap  = 1000;
      m_bad  = 1'b0;
    end else begin
      if (spi_cs_n && spi_sclk) idle_bad = 1'b1;
      if (!spi_cs_n) begin
        if (p_cs) begin
          if (m_gap < 1000) chk("cs_gap", 32'(m_gap >= CS_GAP), 1);
          m_cnt  = 0;
          m_bits = 0;
          m_bad  = 1'b0;
        end
        m_cnt++;
        if (spi_sclk && !p_sclk) begin
          m_sh = {m_sh[22:0], spi_sdio};
          m_bits++;
        end
        if (spi_sclk && p_sclk && spi_sdio != p_sdio) m_bad = 1'b1;
      end else begin
        if (!p_cs) begin
          frames++;
          chk("cs_low_cycles", m_cnt, CS_LOW);
          chk("frame_bits", m_bits, 24);
          chk("sdio_stable", m_bad, 0);
          if (q.size() == 0) begin
            chk("unexpected_frame", m_sh, 0);
          end else begin
            exp_w = q.pop_front();
            chk("frame", m_sh, {3'b000, exp_w});
          end
          m_gap = 0;
        end
        if (m_gap < 1000) m_gap++;
      end
      if (done) done_cnt++;
      if (wr_ack) ack_cnt++;
    end
    p_cs   = spi_cs_n;
    p_sclk = spi_sclk;
    p_sdio = spi_sdio;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_table();
    for (int i = 0; i < N; i++) q.push_back(tbl[i]);
    q.push_back({13'h05A, 8'h01});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
    step(2);
  endtask

  task automatic wait_ack(input int maxc);
    int n = 0;
    while (!wr_ack && n < maxc) begin
      step();
      n++;
    end
    chk("ack_seen", wr_ack, 1);
  endtask

  initial begin
    int n;
    tbl[0] = {13'h004, 8'h01};
    tbl[1] = {13'h008, 8'h7F};
    tbl[2] = {13'h03D, 8'h08};
    step(3);
    chk("reset", {spi_cs_n, spi_sclk, spi_sdio, busy, done,
                  wr_ack, cfg_ok, tbl_index}, {1'b1, 8'b0});
    reset_n = 1'b1;
    step(2);

    // single write
    wr_addr = 13'h045;
    wr_data = 8'h02;
    wr_req  = 1'b1;
    q.push_back({13'h045, 8'h02});
    wait_ack(20);
    chk("t1_busy", busy, 1);
    wr_req = 1'b0;
    wait_idle(2000);
    chk("t1_acks", ack_cnt, 1);
    chk("t1_done", done_cnt, 0);
    chk("t1_frames", frames, 1);
    chk("t1_cfg_ok", cfg_ok, 0);

    // table run with update commit
    push_table();
    pulse_start();
    chk("t2_busy", busy, 1);
    wait_idle(3000);
    chk("t2_frames", frames, 5);
    chk("t2_done", done_cnt, 1);
    chk("t2_cfg_ok", cfg_ok, 1);
    chk("t2_index", tbl_index, 0);

    // start and wr_req together
    push_table();
    q.push_back({13'h1AB, 8'h5C});
    wr_addr = 13'h1AB;
    wr_data = 8'h5C;
    wr_req  = 1'b1;
    pulse_start();
    wait_ack(3000);
    chk("t3_ack_after_done", done_cnt, 2);
    wr_req = 1'b0;
    wait_idle(2000);
    chk("t3_frames", frames, 10);
    chk("t3_done", done_cnt, 2);
    chk("t3_acks", ack_cnt, 2);

    // start while busy is ignored
    push_table();
    pulse_start();
    step(300);
    pulse_start();
    wait_idle(3000);
    chk("t5_frames", frames, 14);
    chk("t5_done", done_cnt, 3);

    // reset mid-frame
    push_table();
    pulse_start();
    n = 0;
    while (!(frames == 16 && m_bits == 10 && !spi_cs_n) && n < 3000) begin
      step();
      n++;
    end
    chk("t4_reached_bit10", 32'(n < 3000), 1);
    reset_n = 1'b0;
    step();
    chk("t4_reset", {spi_cs_n, spi_sclk, busy, cfg_ok}, 4'b1000);
    step(2);
    q.delete();
    reset_n = 1'b1;
    step();
    chk("t4_index", tbl_index, 0);
    push_table();
    pulse_start();
    wait_idle(3000);
    chk("t4_frames", frames, 20);
    chk("t4_done", done_cnt, 4);
    chk("t4_cfg_ok", cfg_ok, 1);

    chk("sclk_low_cs_high", idle_bad, 0);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
